// File: rtl/rbm_sample_driver_pkg.sv
// Shared types for the RBM sample driver: controller states and a width helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rbm_sample_driver_pkg;

  // Controller phases for streaming one sample into the inference core
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRST    = 3'd1,
    S_PRESENT = 3'd2,
    S_CAPTURE = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Index width for n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rbm_sample_driver_argmax.sv
// Argmax over a flat packed vector of signed elements; ties go to the lowest index.
// Latency: purely combinational.
// Backpressure: none.
module rbm_sample_driver_argmax #(
  parameter int bitlength  = 12,
  parameter int output_dim = 2,
  parameter int IW         = 1
) (
  input  logic [output_dim*bitlength-1:0] i_vec,
  output logic [IW-1:0]                   o_idx
);

  logic signed [bitlength-1:0] w_best_val;
  logic [IW-1:0]               w_best_idx;

  // Strict greater-than keeps the earliest index on ties; saturated values compare as plain numbers
  always_comb begin
    w_best_val = $signed(i_vec[bitlength-1:0]);
    w_best_idx = '0;
    for (int i = 1; i < output_dim; i++) begin
      if ($signed(i_vec[i*bitlength +: bitlength]) > w_best_val) begin
        w_best_val = $signed(i_vec[i*bitlength +: bitlength]);
        w_best_idx = IW'(i);
      end
    end
  end

  assign o_idx = w_best_idx;

endmodule

// File: rtl/rbm_sample_driver.sv
// Streams ROM samples into the RBM core, waits for finish, emits argmax class per sample.
// Latency: start->data_valid 1+reset_cycles; core_finish->result_valid 1; result->next data_valid reset_cycles+2.
// Backpressure: none; the core's level finish flag paces the run, bounded by timeout_cycles.
module rbm_sample_driver
  import rbm_sample_driver_pkg::*;
#(
  parameter int bitlength      = 12,
  parameter int input_dim      = 15,
  parameter int output_dim     = 2,
  parameter int sample_num     = 16,
  parameter int reset_cycles   = 2,
  parameter int timeout_cycles = 1000000,
  // Sample ROM image, sample k at [k*input_dim*bitlength +: input_dim*bitlength];
  // supplied as a parameter so the block needs no time-zero file load
  parameter logic [sample_num*input_dim*bitlength-1:0] sample_rom = '0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  output logic                                core_reset,
  output logic                                data_valid,
  output logic [input_dim*bitlength-1:0]      InputData,
  input  logic [output_dim*bitlength-1:0]     OutputData,
  input  logic                                core_finish,
  output logic                                result_valid,
  output logic [idx_w(output_dim)-1:0]        result_class,
  output logic [idx_w(sample_num)-1:0]        result_index,
  output logic                                busy,
  output logic                                done,
  output logic                                timeout_error
);

  localparam int SW  = input_dim * bitlength;
  localparam int CW  = idx_w(output_dim);
  localparam int PW  = idx_w(sample_num);
  localparam int RCW = idx_w(reset_cycles);
  localparam int TW  = idx_w(timeout_cycles);

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [RCW-1:0]  r_rcnt;
  logic [TW-1:0]   r_wcnt;
  logic [SW-1:0]   r_input;
  logic [CW-1:0]   r_class;
  logic [PW-1:0]   r_index;
  logic            r_timeout;

  logic [CW-1:0]   w_argmax;
  logic [PW-1:0]   w_ptr_inc;
  logic [SW-1:0]   w_rom_nxt;
  logic            w_start_ok;
  logic            w_crst_last;
  logic            w_finish_hit;
  logic            w_timeout_hit;
  logic            w_ptr_last;

  rbm_sample_driver_argmax #(
    .bitlength  (bitlength),
    .output_dim (output_dim),
    .IW         (CW)
  ) u_argmax (
    .i_vec (OutputData),
    .o_idx (w_argmax)
  );

  assign w_start_ok    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_crst_last   = (r_rcnt == RCW'(reset_cycles - 1));
  // The first PRESENT cycle can still see a finish left over from before the core reset
  assign w_finish_hit  = (r_state == S_PRESENT) && core_finish && (r_wcnt != '0);
  assign w_timeout_hit = (r_state == S_PRESENT) && !w_finish_hit && (r_wcnt == TW'(timeout_cycles - 1));
  assign w_ptr_last    = (r_ptr == PW'(sample_num - 1));
  assign w_ptr_inc     = r_ptr + 1'b1;
  assign w_rom_nxt     = sample_rom[int'(w_ptr_inc)*SW +: SW];

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CRST;
      S_CRST:    if (w_crst_last) w_next = S_PRESENT;
      S_PRESENT: if (w_finish_hit || w_timeout_hit) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_NEXT;
      S_NEXT:    w_next = w_ptr_last ? S_DONE : S_CRST;
      S_DONE:    if (start) w_next = S_CRST;
      default:   w_next = S_IDLE;
    endcase
  end

  // Counters, sample pointer, presented sample and captured result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr     <= '0;
      r_rcnt    <= '0;
      r_wcnt    <= '0;
      r_input   <= '0;
      r_class   <= '0;
      r_index   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_rcnt <= (r_state == S_CRST && !w_crst_last) ? r_rcnt + 1'b1 : '0;
      r_wcnt <= (r_state == S_PRESENT) ? r_wcnt + 1'b1 : '0;
      if (w_start_ok) begin
        r_ptr     <= '0;
        r_input   <= sample_rom[SW-1:0];
        r_timeout <= 1'b0;
      end
      if (r_state == S_NEXT && !w_ptr_last) begin
        r_ptr   <= w_ptr_inc;
        r_input <= w_rom_nxt;
      end
      if (w_finish_hit) begin
        r_class <= w_argmax;
        r_index <= r_ptr;
      end
      if (w_timeout_hit) begin
        r_class   <= '0;
        r_index   <= r_ptr;
        r_timeout <= 1'b1;
      end
    end
  end

  // Outputs decoded from state; the core is released only while a sample is presented or captured
  always_comb begin
    core_reset   = !(r_state == S_PRESENT || r_state == S_CAPTURE);
    data_valid   = (r_state == S_PRESENT);
    result_valid = (r_state == S_CAPTURE);
    busy         = !(r_state == S_IDLE || r_state == S_DONE);
    done         = (r_state == S_DONE);
  end

  assign InputData     = r_input;
  assign result_class  = r_class;
  assign result_index  = r_index;
  assign timeout_error = r_timeout;

endmodule

// File: tb/tb_rbm_sample_driver.sv
module tb_rbm_sample_driver;

  localparam int BL = 12;
  localparam int ID = 15;
  localparam int OD = 2;
  localparam int SN = 4;
  localparam int RC = 2;
  localparam int TO = 50;
  localparam int SW = ID * BL;
  localparam int OW = OD * BL;

  function automatic logic [SN*SW-1:0] gen_rom();
    logic [SN*SW-1:0] r;
    logic [31:0]      s;
    r = '0;
    s = 32'h01234567;
    for (int i = 0; i < SN * ID; i++) begin
      s = s * 32'd1103515245 + 32'd12345;
      r[i*BL +: BL] = s[27:16];
    end
    return r;
  endfunction

  localparam logic [SN*SW-1:0] ROM = gen_rom();

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          core_finish = 1'b0;
  logic [OW-1:0] OutputData = '0;
  logic          core_reset, data_valid, result_valid, busy, done, timeout_error;
  logic [SW-1:0] InputData;
  logic [0:0]    result_class;
  logic [1:0]    result_index;

  rbm_sample_driver #(
    .bitlength      (BL),
    .input_dim      (ID),
    .output_dim     (OD),
    .sample_num     (SN),
    .reset_cycles   (RC),
    .timeout_cycles (TO),
    .sample_rom     (ROM)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .core_reset    (core_reset),
    .data_valid    (data_valid),
    .InputData     (InputData),
    .OutputData    (OutputData),
    .core_finish   (core_finish),
    .result_valid  (result_valid),
    .result_class  (result_class),
    .result_index  (result_index),
    .busy          (busy),
    .done          (done),
    .timeout_error (timeout_error)
  );

  always #5 clock = ~clock;

  // One planned cycle: what the bench drives and what it must observe
  typedef struct {
    bit            start;
    bit            rst;
    bit            fin;
    logic [OW-1:0] od;
    bit            cr, dv, rv, bz, dn, to;
    bit            chk_res;
    int            cls;
    int            idx;
    logic [SW-1:0] inp;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  bit   cur_vld = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Model state carried between planned cycles
  logic [SW-1:0] m_inp = '0;
  bit            m_to = 1'b0;
  bit            m_done = 1'b0;

  // Per-sample scenario: stale finish, finish PRESENT cycle (0 = never), outputs, literal class (-1 = model)
  bit sc_st  [SN];
  int sc_f   [SN];
  int sc_e0  [SN];
  int sc_e1  [SN];
  int sc_cls [SN];

  function automatic cyc_t base();
    cyc_t r;
    r.start = 1'b0; r.rst = 1'b0; r.fin = 1'b0; r.od = '0;
    r.cr = 1'b1; r.dv = 1'b0; r.rv = 1'b0; r.bz = 1'b0;
    r.dn = m_done; r.to = m_to; r.chk_res = 1'b0;
    r.cls = 0; r.idx = 0; r.inp = m_inp;
    return r;
  endfunction

  function automatic logic [OW-1:0] pack_od(input int e0, input int e1);
    logic [BL-1:0] a, b;
    a = BL'(e0);
    b = BL'(e1);
    return {b, a};
  endfunction

  function automatic bit busy_start();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic plan_idle(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r = base();
      r.fin = 1'b1;
      r.od = pack_od(5, -5);
      r.chk_res = 1'b1;
      plan.push_back(r);
    end
  endtask

  task automatic plan_run();
    cyc_t r;
    int L, cls;
    logic [OW-1:0] od;
    od = '0;
    r = base(); r.start = 1'b1; plan.push_back(r);
    m_to = 1'b0;
    m_done = 1'b0;
    for (int k = 0; k < SN; k++) begin
      m_inp = ROM[k*SW +: SW];
      od = pack_od(sc_e0[k], sc_e1[k]);
      for (int c = 0; c < RC; c++) begin
        r = base(); r.bz = 1'b1; r.od = od; r.fin = sc_st[k]; r.start = busy_start();
        plan.push_back(r);
      end
      L = (sc_f[k] == 0) ? TO : sc_f[k];
      for (int p = 1; p <= L; p++) begin
        r = base(); r.bz = 1'b1; r.cr = 1'b0; r.dv = 1'b1; r.od = od; r.start = busy_start();
        r.fin = (sc_st[k] && p == 1) || (sc_f[k] != 0 && p >= sc_f[k]);
        plan.push_back(r);
      end
      if (sc_f[k] == 0) begin
        m_to = 1'b1;
        cls = 0;
      end else if (sc_cls[k] >= 0) begin
        cls = sc_cls[k];
      end else begin
        cls = (sc_e1[k] > sc_e0[k]) ? 1 : 0;
      end
      r = base(); r.bz = 1'b1; r.cr = 1'b0; r.rv = 1'b1; r.chk_res = 1'b1;
      r.cls = cls; r.idx = k; r.od = od; r.fin = (sc_f[k] != 0); r.start = busy_start();
      plan.push_back(r);
      r = base(); r.bz = 1'b1; r.od = od; r.start = busy_start();
      plan.push_back(r);
    end
    m_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = base(); r.fin = 1'b1; r.od = od;
      plan.push_back(r);
    end
  endtask

  task automatic plan_reset_mid();
    cyc_t r;
    logic [OW-1:0] od;
    od = pack_od(100, -100);
    r = base(); r.start = 1'b1; plan.push_back(r);
    m_to = 1'b0;
    m_done = 1'b0;
    m_inp = ROM[SW-1:0];
    for (int c = 0; c < RC; c++) begin
      r = base(); r.bz = 1'b1; r.od = od; r.start = 1'b1;
      plan.push_back(r);
    end
    for (int p = 1; p <= 3; p++) begin
      r = base(); r.bz = 1'b1; r.cr = 1'b0; r.dv = 1'b1; r.od = od;
      r.start = (p == 2);
      r.fin = (p == 3);
      r.rst = (p == 3);
      plan.push_back(r);
    end
    m_inp = '0;
    plan_idle(3);
  endtask

  task automatic rand_scen();
    for (int k = 0; k < SN; k++) begin
      sc_st[k]  = ($urandom_range(0, 3) == 0);
      sc_f[k]   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 40));
      sc_e0[k]  = int'($urandom_range(0, 4095)) - 2048;
      sc_e1[k]  = ($urandom_range(0, 3) == 0) ? sc_e0[k] : int'($urandom_range(0, 4095)) - 2048;
      sc_cls[k] = -1;
    end
  endtask

  function automatic void chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endfunction

  // Compare process: every planned cycle is checked mid-cycle
  always @(negedge clock) begin
    if (cur_vld) begin
      chk("core_reset", SW'(core_reset), SW'(cur.cr));
      chk("data_valid", SW'(data_valid), SW'(cur.dv));
      chk("result_valid", SW'(result_valid), SW'(cur.rv));
      chk("busy", SW'(busy), SW'(cur.bz));
      chk("done", SW'(done), SW'(cur.dn));
      chk("timeout_error", SW'(timeout_error), SW'(cur.to));
      chk("InputData", InputData, cur.inp);
      if (cur.chk_res) begin
        chk("result_class", SW'(result_class), SW'(cur.cls));
        chk("result_index", SW'(result_index), SW'(cur.idx));
      end
      cyc++;
    end
  end

  initial begin
    plan_idle(2);

    // Directed: 5 vs -3, tie, saturated compare, most negative value with stale finish
    sc_st  = '{0, 0, 0, 1};
    sc_f   = '{11, 4, 6, 7};
    sc_e0  = '{-3, 7, 2047, -2048};
    sc_e1  = '{5, 7, 2046, 0};
    sc_cls = '{1, 0, 0, 1};
    plan_run();

    // Random run with a forced timeout on sample 1
    rand_scen();
    sc_f[1] = 0;
    plan_run();

    for (int r = 0; r < 4; r++) begin
      rand_scen();
      plan_run();
    end

    plan_reset_mid();
    rand_scen();
    plan_run();

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    while (plan.size() > 0) begin
      cur = plan.pop_front();
      reset = cur.rst;
      start = cur.start;
      core_finish = cur.fin;
      OutputData = cur.od;
      cur_vld = 1'b1;
      @(posedge clock);
      #1;
    end
    cur_vld = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
